// File: rtl/hash_core_arbiter.sv
// Round-robin arbiter and sequencer sharing one hash core among N byte-stream
// requesters. A requester owns the core for a whole message, its bytes are
// forwarded with the message length held on core_counter, and the digest is
// returned tagged with the requester id once the core signals completion.
module hash_core_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              req,
    input  logic [64*N-1:0]           req_len,
    input  logic [N-1:0]              byte_valid,
    input  logic [8*N-1:0]            byte_data,
    output logic [N-1:0]              byte_ready,
    output logic [N-1:0]              grant,
    output logic                      core_m_valid,
    output logic [7:0]                core_message,
    output logic [63:0]               core_counter,
    input  logic                      core_hash_ready,
    input  logic [31:0]               core_digest,
    output logic                      dig_valid,
    output logic [$clog2(N)-1:0]      dig_id,
    output logic [31:0]               dig_data,
    output logic                      busy
);

    localparam int unsigned IDW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_ZERO,
        S_WAIT
    } state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] g_idx;
    logic [IDW-1:0] last;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] cand;
    logic [N-1:0]   pick_oh;
    logic           found;
    logic [63:0]    pick_len;
    logic [63:0]    len;
    logic [63:0]    rem;
    logic           hq;
    logic           xfer;
    logic           done;

    // Cyclic search for the first pending request starting just after the last winner.
    always_comb begin
        pick    = last;
        cand    = '0;
        pick_oh = '0;
        found   = 1'b0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = IDW'((32'(last) + off) % N);
            if (!found && req[cand]) begin
                found         = 1'b1;
                pick          = cand;
                pick_oh[cand] = 1'b1;
            end
        end
        pick_len = req_len[{pick, 6'd0} +: 64];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and core-side muxing of the granted requester.
    always_comb begin
        state_nx     = state;
        byte_ready   = '0;
        core_m_valid = 1'b0;
        core_message = '0;
        core_counter = len;
        xfer         = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nx = (pick_len != 64'd0) ? S_FEED : S_ZERO;
                end
            end
            S_FEED: begin
                byte_ready   = grant;
                core_m_valid = byte_valid[g_idx];
                core_message = byte_data[{g_idx, 3'd0} +: 8];
                xfer         = byte_valid[g_idx];
                if (xfer && rem == 64'd1) begin
                    state_nx = S_WAIT;
                end
            end
            S_ZERO: begin
                core_m_valid = 1'b1;
                core_counter = '0;
                state_nx     = S_WAIT;
            end
            S_WAIT: begin
                // Only a fresh rise counts; a level left high by the previous message is stale.
                done = core_hash_ready & ~hq;
                if (done) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Grant, length/remaining counters, completion edge detect and digest return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            g_idx     <= '0;
            last      <= IDW'(N - 1);
            len       <= '0;
            rem       <= '0;
            hq        <= 1'b0;
            dig_valid <= 1'b0;
            dig_id    <= '0;
            dig_data  <= '0;
        end else begin
            hq        <= core_hash_ready;
            dig_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant <= pick_oh;
                        g_idx <= pick;
                        len   <= pick_len;
                        rem   <= pick_len;
                    end
                end
                S_FEED: begin
                    if (xfer) begin
                        rem <= rem - 64'd1;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        dig_data  <= core_digest;
                        dig_id    <= g_idx;
                        dig_valid <= 1'b1;
                        last      <= g_idx;
                        grant     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule
